// File: rtl/fetch_sequencer.sv
// Instruction fetch stage: owns the PC, drives instruction memory and registers the IF/ID word.
// Optional performance counters are enabled with `define FETCH_PERF_COUNT_EN.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          ADDR_IDX_BITS = 10
) (
   input  logic        Clk,
   input  logic        Reset,
   output logic [31:0] IMemAddress,
   input  logic [31:0] IMemInstruction,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] RedirectTarget,
   output logic        OutValid,
   output logic [31:0] OutInstruction,
   output logic [31:0] OutPC,
   output logic [31:0] OutPCPlus4,
   output logic [31:0] FetchCount,
   output logic [31:0] StallCount
);

   // Word-aligned and confined to the instruction memory's byte range.
   localparam logic [31:0] PC_MASK =
      32'(((64'd1) << (ADDR_IDX_BITS + 2)) - 64'd1) & ~32'h0000_0003;

   typedef enum logic [1:0] {
      S_START = 2'd0,
      S_EMPTY = 2'd1,
      S_VALID = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_pc4_q, out_pc4_d;
   logic [31:0] pc_plus4;
   logic        capture;

   assign pc_plus4 = (pc_q + 32'd4) & PC_MASK;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      valid_d   = valid_q;
      instr_d   = instr_q;
      out_pc_d  = out_pc_q;
      out_pc4_d = out_pc4_q;
      capture   = 1'b0;
      case (state_q)
         S_START: begin
            state_d = S_EMPTY;
            valid_d = 1'b0;
            if (Redirect) begin
               pc_d = RedirectTarget & PC_MASK;
            end
         end
         S_EMPTY, S_VALID: begin
            if (Redirect) begin
               pc_d    = RedirectTarget & PC_MASK;
               valid_d = 1'b0;
               state_d = S_EMPTY;
            end else if (!Stall) begin
               capture   = 1'b1;
               instr_d   = IMemInstruction;
               out_pc_d  = pc_q;
               out_pc4_d = pc_plus4;
               valid_d   = 1'b1;
               pc_d      = pc_plus4;
               state_d   = S_VALID;
            end
         end
         default: begin
            state_d = S_START;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q   <= S_START;
         pc_q      <= RESET_PC;
         valid_q   <= 1'b0;
         instr_q   <= 32'd0;
         out_pc_q  <= 32'd0;
         out_pc4_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         out_pc_q  <= out_pc_d;
         out_pc4_q <= out_pc4_d;
      end
   end

`ifdef FETCH_PERF_COUNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (capture && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if ((state_q == S_VALID) && Stall && !Redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign FetchCount = fetch_cnt_q;
   assign StallCount = stall_cnt_q;
`else
   assign FetchCount = 32'd0;
   assign StallCount = 32'd0;
`endif

   assign IMemAddress    = pc_q;
   assign OutValid       = valid_q;
   assign OutInstruction = instr_q;
   assign OutPC          = out_pc_q;
   assign OutPCPlus4     = out_pc4_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the instruction memory's read address and registers the returned word into the IF/ID boundary.
- Owns the program counter and sequences fetch under stall (hazard) and redirect (branch/jump) control from the later pipeline stages.
- Instruction memory is word-indexed from address bits [ADDR_IDX_BITS+1:2] with a combinational read, so fetch and capture complete in the same cycle.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset; bits [1:0] must be 0.
- ADDR_IDX_BITS, 10, word-index width of instruction memory (1024 words); PC wraps modulo 2^(ADDR_IDX_BITS+2).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset.
- IMemAddress  output  32  byte address to instruction memory; always equals PC.
- IMemInstruction  input  32  instruction word returned combinationally for IMemAddress.
- Stall  input  1  hold request from hazard unit; freezes PC and output register.
- Redirect  input  1  branch/jump taken; flush and load new PC.
- RedirectTarget  input  32  byte target address for Redirect.
- OutValid  output  1  OutInstruction/OutPC hold a valid fetched instruction.
- OutInstruction  output  32  registered instruction to decode.
- OutPC  output  32  byte address of OutInstruction.
- OutPCPlus4  output  32  OutPC + 4, wrapped.
- FetchCount  output  32  optional performance counter (see Optional Feature).
- StallCount  output  32  optional performance counter (see Optional Feature).

Behaviour:
- Reset (Reset==0 at a rising Clk edge): PC=RESET_PC, OutValid=0, OutInstruction=0, OutPC=0, OutPCPlus4=0, counters=0, state=START. Reset has priority over all other inputs.
- State START: lasts one cycle after reset release, no fetch, OutValid=0. Goes to EMPTY, or to EMPTY with the new PC if Redirect is high.
- State EMPTY (OutValid=0):
  - If !Redirect && !Stall: capture IMemInstruction, PC, PC+4 into the output registers, set OutValid=1, PC<=PC+4, go to VALID.
  - Stall in EMPTY: hold everything.
- State VALID (OutValid=1):
  - If !Stall: replace the output with the next fetch (same capture as EMPTY) and advance the PC; stay in VALID.
  - If Stall: hold PC and all output registers unchanged. There is no back-to-back loss or duplication.
- Redirect, any state except reset: PC<=RedirectTarget with bits [1:0] forced to 0 and bits above ADDR_IDX_BITS+1 forced to 0; OutValid<=0; go to EMPTY. The first target instruction appears with OutValid=1 one cycle later, giving a 1-bubble penalty.
- Redirect and Stall together: Redirect wins.
- Arithmetic: PC+4 wraps modulo 2^(ADDR_IDX_BITS+2). For example, PC=0x00000FFC with ADDR_IDX_BITS=10 advances to 0x00000000. OutPCPlus4 wraps the same way. Upper PC bits are always 0.
- Fetch latency: address presented on cycle N, instruction visible on OutInstruction after edge N+1.

Optional Feature:
- Macro: FETCH_PERF_COUNT_EN.
- Defined: FetchCount increments on every capture into the output register. StallCount increments on every cycle where state is VALID and Stall=1 and Redirect=0. Both counters are 32-bit, saturate at 0xFFFFFFFF and clear on reset.
- Not defined: no counter logic; FetchCount and StallCount are tied to 0.

Test Plan:
- Reset 3 cycles, release, memory[i]=i*3, no Stall -> OutValid rises 2 cycles after release; OutPC sequence 0x0,0x4,0x8 with OutInstruction 0,3,6; OutPCPlus4 = OutPC+4.
- Stall high 3 cycles while OutPC=0x8 -> OutPC/OutInstruction hold 0x8/6; after release the next output is 0x0C/9; StallCount=3 with macro defined.
- Redirect with RedirectTarget=0x00000043 while VALID -> next cycle OutValid=0; following cycle OutPC=0x40, OutInstruction=48.
- Redirect and Stall asserted same cycle, target 0x100 -> flush occurs; after Stall drops OutPC=0x100, OutInstruction=192.
- Redirect to 0xFF8, run 3 fetches -> OutPC 0xFF8, 0xFFC, 0x000; OutPCPlus4 at 0xFFC = 0x000.
- Reset asserted mid-stream at OutPC=0x20 -> next edge OutValid=0, PC=RESET_PC, counters 0; fetch resumes from 0x0.
